// File: rtl/xconf_loader.sv
// xconf_loader: walks a list of {addr, data} entries held in a synchronous-read
// list memory and replays them as single-cycle xconf control writes. An optional
// clear-command write can precede the list. Entries whose address falls outside
// the valid config range (and is not the clear address) are skipped and raise a
// sticky error.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            one-cycle load request (ignored while busy)
//   clear_first_i      issue the clear write before the list (sampled with start)
//   abort_i            terminate the current load
//   list_base_i        first list entry address (sampled with start)
//   list_len_i         number of entries, up to 2^LIST_AW (sampled with start)
//   lst_en_o/addr_o    list memory read request
//   lst_data_i         {addr, data} entry, valid one cycle after lst_en_o
//   ctr_valid_o/we_o   xconf write strobe
//   ctr_addr_o         xconf write address
//   ctr_data_in_o      xconf write data
//   busy_o             load in progress
//   done_o             one-cycle completion pulse
//   err_o              sticky range error, cleared by the next accepted start
module xconf_loader #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 11,
  parameter int unsigned LIST_AW    = 8,
  parameter int unsigned CONF_RANGE = 40,
  parameter int unsigned CLEAR_ADDR = 63
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     clear_first_i,
  input  logic                     abort_i,
  input  logic [LIST_AW-1:0]       list_base_i,
  input  logic [LIST_AW:0]         list_len_i,
  output logic                     lst_en_o,
  output logic [LIST_AW-1:0]       lst_addr_o,
  input  logic [ADDR_W+DATA_W-1:0] lst_data_i,
  output logic                     ctr_valid_o,
  output logic                     ctr_we_o,
  output logic [ADDR_W-1:0]        ctr_addr_o,
  output logic [DATA_W-1:0]        ctr_data_in_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  typedef enum logic [2:0] {StIdle, StClear, StFetch, StCapture, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [LIST_AW-1:0]  base_q, base_d;
  logic [LIST_AW:0]    len_q, len_d;
  logic [LIST_AW:0]    idx_q, idx_d;
  logic [LIST_AW:0]    idx_inc;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   caddr_q, caddr_d;
  logic [DATA_W-1:0]   cdata_q, cdata_d;
  logic                addr_ok;
  logic                strobe;

  // Widen the address before comparing so CONF_RANGE may exceed 2^ADDR_W.
  assign addr_ok = (32'(caddr_q) < CONF_RANGE) || (caddr_q == ADDR_W'(CLEAR_ADDR));
  assign idx_inc = idx_q + {{LIST_AW{1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    err_d    = err_q;
    caddr_d  = caddr_q;
    cdata_d  = cdata_q;
    strobe   = 1'b0;
    lst_en_o = 1'b0;
    done_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d = list_base_i;
          len_d  = list_len_i;
          idx_d  = '0;
          err_d  = 1'b0;
          if (clear_first_i) begin
            state_d = StClear;
            // Preload the clear command so it is on the bus during StClear.
            caddr_d = ADDR_W'(CLEAR_ADDR);
            cdata_d = '0;
          end else if (list_len_i == '0) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StClear: begin
        strobe  = 1'b1;
        state_d = (len_q == '0) ? StDone : StFetch;
      end
      StFetch: begin
        lst_en_o = 1'b1;
        state_d  = StCapture;
      end
      StCapture: begin
        caddr_d = lst_data_i[ADDR_W+DATA_W-1:DATA_W];
        cdata_d = lst_data_i[DATA_W-1:0];
        state_d = StWrite;
      end
      StWrite: begin
        if (addr_ok) strobe = 1'b1;
        else         err_d  = 1'b1;
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? StDone : StFetch;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything: no strobe, no done, error and bus values frozen.
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      idx_d   = '0;
      err_d   = err_q;
      caddr_d = caddr_q;
      cdata_d = cdata_q;
      strobe  = 1'b0;
      done_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end

  // Address wraps naturally through the LIST_AW-bit sum.
  assign lst_addr_o    = (state_q == StFetch) ? (base_q + idx_q[LIST_AW-1:0]) : '0;
  assign ctr_valid_o   = strobe;
  assign ctr_we_o      = strobe;
  assign ctr_addr_o    = caddr_q;
  assign ctr_data_in_o = cdata_q;
  assign busy_o        = (state_q != StIdle);
  assign err_o         = err_q;

endmodule
